jleugeri_button_conditioner: RTL
================================

JLEUGERI_BUTTON_CONDITIONER -- requirements
Module: jleugeri_button_conditioner

Interface
REQ-001: Parameter N_BUTTONS, default 4, number of independent button channels (1..8).
REQ-002: Parameter DEBOUNCE_CYCLES, default 1000, consecutive stable cycles required to accept a level change (>=2).
REQ-003: Parameter LONG_PRESS_CYCLES, default 50000, held cycles after acceptance before a long-press pulse (>=2).
REQ-004: clk  input  1  single system clock; all state on rising edge.
REQ-005: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006: ena  input  1  block enable; high when design selected.
REQ-007: btn_raw  input  N_BUTTONS  asynchronous, bouncy button pins, active-high.
REQ-008: btn_level  output  N_BUTTONS  debounced, registered button level.
REQ-009: btn_press  output  N_BUTTONS  one-cycle pulse on accepted 0->1 transition.
REQ-010: btn_release  output  N_BUTTONS  one-cycle pulse on accepted 1->0 transition.
REQ-011: btn_long  output  N_BUTTONS  one-cycle pulse when a held press reaches LONG_PRESS_CYCLES.

Function
REQ-012: Each btn_raw bit shall pass through a two-flop synchronizer before any other logic; sync output = raw value two rising edges earlier.
REQ-013: Each channel shall hold a debounce counter of width $clog2(DEBOUNCE_CYCLES), incrementing every cycle synchronized input != btn_level.
REQ-014: Any cycle synchronized input == btn_level shall clear that channel's debounce counter to 0 (bounce restarts count).
REQ-015: On a mismatching cycle with counter == DEBOUNCE_CYCLES-1, btn_level shall toggle and the counter clear on the same edge.
REQ-016: Total latency: clean raw edge to btn_level change = DEBOUNCE_CYCLES+2 rising edges.
REQ-017: btn_press (btn_release) shall be high exactly in the cycle btn_level first reads 1 (0), registered, same edge as btn_level update.
REQ-018: Channels are fully independent; simultaneous transitions on several channels shall produce simultaneous pulses.
REQ-019: While ena=0: synchronizers keep running, debounce and long counters held at 0, btn_level held, all pulse outputs 0.
REQ-020: On ena 0->1 no pulse shall be generated until a full debounce interval elapses.
REQ-021: Counters shall never wrap; maximum value DEBOUNCE_CYCLES-1 before clear.

Reset
REQ-022: rst_n=0 shall asynchronously clear synchronizers, btn_level, all counters, btn_press, btn_release, btn_long to 0.
REQ-023: Reset asserted mid-debounce or mid-hold shall discard progress; after release, a button already held produces btn_press after DEBOUNCE_CYCLES+2 edges.

Configuration
REQ-024: Macro BUTTON_LONG_PRESS_EN shall gate long-press logic.
REQ-025: With macro defined: per-channel hold counter (width $clog2(LONG_PRESS_CYCLES)) counts cycles btn_level=1, cleared when btn_level=0 or ena=0.
REQ-026: With macro defined: btn_long pulses one cycle when hold counter reaches LONG_PRESS_CYCLES-1; counter then saturates, no repeat until release.
REQ-027: With macro undefined: no hold counters instantiated; btn_long tied to 0.

Verification (DEBOUNCE_CYCLES=8, LONG_PRESS_CYCLES=32, N_BUTTONS=4)
REQ-028: Clean press: btn_raw[0] 0->1 at edge 0 -> btn_level[0]=1 and btn_press[0]=1 at edge 10, btn_press[0]=0 at edge 11.
REQ-029: Bounce: btn_raw[1] toggles high 5 cycles, low 1, high steady -> single btn_press[1], no btn_release[1], level rises 10 edges after final rise.
REQ-030: Glitch: btn_raw[2] high for 7 cycles then low -> btn_level[2] stays 0, no pulses.
REQ-031: Simultaneous: btn_raw=4'b1111 held, then 4'b0000 -> btn_press=4'b1111 in one cycle, later btn_release=4'b1111 in one cycle.
REQ-032: Long press (macro defined): hold btn_raw[3] -> btn_long[3] exactly one pulse 32 cycles after btn_press[3]; macro undefined -> btn_long stays 0.
REQ-033: Reset/enable: assert rst_n=0 at counter=5 -> all outputs 0 immediately; ena=0 during held press -> no pulses, btn_level unchanged.

Source files
------------

// File: rtl/jleugeri_button_conditioner.sv
// jleugeri_button_conditioner: per-channel synchronizer, debouncer and press/release/long-press pulse generator
//
// Ports:
//   clk          system clock, all state on the rising edge
//   rst_n        asynchronous active-low reset
//   ena          block enable; while low, counters held at 0, level held, pulses 0
//   btn_raw      raw asynchronous button pins (active-high)
//   btn_level    debounced registered level
//   btn_press    one-cycle pulse on accepted 0->1
//   btn_release  one-cycle pulse on accepted 1->0
//   btn_long     one-cycle pulse when a held press reaches LONG_PRESS_CYCLES
//
// Optional feature: define BUTTON_LONG_PRESS_EN to build the hold counters;
// otherwise btn_long is tied to 0.
module jleugeri_button_conditioner #(
    parameter int N_BUTTONS         = 4,
    parameter int DEBOUNCE_CYCLES   = 1000,
    parameter int LONG_PRESS_CYCLES = 50000
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 ena,
    input  logic [N_BUTTONS-1:0] btn_raw,
    output logic [N_BUTTONS-1:0] btn_level,
    output logic [N_BUTTONS-1:0] btn_press,
    output logic [N_BUTTONS-1:0] btn_release,
    output logic [N_BUTTONS-1:0] btn_long
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [DW-1:0] DB_MAX = DW'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_LONG_PRESS_EN
    localparam int LW = $clog2(LONG_PRESS_CYCLES);
    localparam logic [LW-1:0] LP_MAX = LW'(LONG_PRESS_CYCLES - 1);
`endif

    logic [N_BUTTONS-1:0] r_sync1, r_sync2;

    // Synchronizers run regardless of ena so the level is fresh when re-enabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    for (genvar g = 0; g < N_BUTTONS; g++) begin : g_ch
        logic [DW-1:0] r_db_cnt;
        logic          r_level, r_press, r_release;
        logic          w_mismatch, w_toggle;

        assign w_mismatch = ena && (r_sync2[g] != r_level);
        // The D-th consecutive mismatching cycle accepts the new level.
        assign w_toggle   = w_mismatch && (r_db_cnt == DB_MAX);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_db_cnt  <= '0;
                r_level   <= 1'b0;
                r_press   <= 1'b0;
                r_release <= 1'b0;
            end else begin
                r_db_cnt  <= (w_mismatch && !w_toggle) ? r_db_cnt + 1'b1 : '0;
                r_level   <= r_level ^ w_toggle;
                r_press   <= w_toggle && !r_level;
                r_release <= w_toggle && r_level;
            end
        end

        assign btn_level[g]   = r_level;
        assign btn_press[g]   = r_press;
        assign btn_release[g] = r_release;

`ifdef BUTTON_LONG_PRESS_EN
        logic [LW-1:0] r_hold_cnt;
        logic          r_long, r_long_done;
        logic          w_hold;

        assign w_hold = ena && r_level;

        // Counter saturates at LP_MAX; r_long_done blocks repeat pulses until release.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_hold_cnt  <= '0;
                r_long      <= 1'b0;
                r_long_done <= 1'b0;
            end else begin
                r_hold_cnt  <= !w_hold ? '0 : (r_hold_cnt == LP_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;
                r_long      <= w_hold && (r_hold_cnt == LP_MAX) && !r_long_done;
                r_long_done <= w_hold && (r_long_done || (r_hold_cnt == LP_MAX));
            end
        end

        assign btn_long[g] = r_long;
`else
        assign btn_long[g] = 1'b0;
`endif
    end
endmodule
